sram_stream_writer: RTL and testbench
=====================================

# sram_stream_writer

Byte-stream fill engine for the sky130 1 KB 1RW1R SRAM macro (32x256, 4 byte-lane write mask). It accepts bytes over a valid/ready stream, packs them little-endian into 32-bit words, and drives the macro's read/write port 0 with registered one-cycle write strobes at sequentially incrementing addresses. It is the writer counterpart of the unit that scans SRAM contents through read port 1.

## Interface
- DATA_WIDTH, 32, SRAM word width; must equal 8*NUM_WMASKS.
- ADDR_WIDTH, 8, SRAM address width.
- NUM_WMASKS, 4, byte lanes per word.

- clk  input  1  clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a fill; honored only in IDLE.
- base_addr  input  ADDR_WIDTH  first word address, sampled with start.
- in_valid  input  1  byte available.
- in_ready  output  1  block accepts a byte; handshake = in_valid & in_ready.
- in_data  input  8  byte payload.
- in_last  input  1  final byte of the fill; qualified by handshake.
- csb0  output  1  SRAM chip select, active low.
- web0  output  1  SRAM write enable, active low.
- wmask0  output  NUM_WMASKS  SRAM byte write mask.
- addr0  output  ADDR_WIDTH  SRAM address.
- din0  output  DATA_WIDTH  SRAM write data.
- busy  output  1  high in FILL and DONE.
- done  output  1  one-cycle pulse at the end of a fill.
- full  output  1  sticky: the fill ended because address 2^ADDR_WIDTH-1 was written; cleared by the next accepted start.
- words_written  output  ADDR_WIDTH+1  words written in the current/last fill; cleared by the next accepted start.

## Operation
- States: IDLE, FILL, DONE.
- IDLE: in_ready=0. start -> FILL; addr<=base_addr, lane<=0, pack buffer and mask<=0, words_written<=0, full<=0.
- FILL: in_ready=1 (decoded from state only; no combinational path from in_valid). On handshake, in_data goes into lane `lane` (lane 0 = bits 7:0), the mask bit is set, and lane increments.
- A word completes on a handshake with lane==NUM_WMASKS-1 or in_last=1. On that edge, the output registers load din0=packed word (including the current byte; unfilled lanes 0), wmask0=mask, addr0=addr, csb0=0, web0=0. The buffer, mask and lane clear, addr increments and words_written increments.
- The completing word exits FILL -> DONE if in_last=1 or addr==2^ADDR_WIDTH-1; in the address case full<=1. Otherwise the state stays in FILL. There is no address wrap.
- DONE: lasts exactly one cycle with done=1 and in_ready=0, then -> IDLE.
- The packing buffer is separate from the output registers, so bytes keep being accepted back-to-back while a write strobe is on the ports.
- start outside IDLE is ignored. in_last on a byte that also fills lane NUM_WMASKS-1 produces a single full-mask write.
- rst (any time, including mid-word) forces IDLE asynchronously and discards any partial word; no write is issued.

## Timing
- Reset values: csb0=1, web0=1, wmask0=0, addr0=0, din0=0, in_ready=0, busy=0, done=0, full=0, words_written=0.
- start high in cycle T -> in_ready=1 in T+1.
- A completing handshake in cycle T -> write strobe (csb0=0, web0=0) in T+1 only. In T+2, csb0=1 and web0=1 unless another word completed in T+1. addr0, din0 and wmask0 hold their last values while idle.
- A final handshake in T -> done and the last write strobe together in T+1, in_ready=0 in T+1, IDLE in T+2.
- Maximum throughput: 1 byte/cycle; 1 write strobe per NUM_WMASKS cycles.

## Test plan
- Reset: assert rst mid-cycle with random inputs -> all outputs at reset values immediately; no strobe while rst is high.
- Full words: start, base_addr=0x10; bytes 0x11..0x18 back-to-back, in_last on 0x18 -> writes addr 0x10 din 0x14131211 wmask 0xF, then addr 0x11 din 0x18171615 wmask 0xF; done coincides with the second strobe; words_written=2; full=0.
- Partial last word: base 0x00, 6 bytes 0xA0..0xA5, last on 0xA5 -> addr 0x00 din 0xA3A2A1A0 wmask 0xF; addr 0x01 din 0x0000A5A4 wmask 0x3; done.
- End of memory: base 0xFE, 12 bytes offered with no last -> writes at 0xFE and 0xFF only; in_ready low after the 8th byte; full=1, done pulse, words_written=2; the 9th byte is never accepted.
- Stalls and start: in_valid toggling randomly over 16 bytes -> the same packed words as the gap-free case; a start pulse during FILL leaves addr and words_written unchanged.
- Reset mid-fill: 2 bytes accepted, then rst -> no strobe, IDLE. New start base 0x40 with 4 bytes 0x01..0x04 + last -> single write addr 0x40 din 0x04030201 wmask 0xF.

Source files
------------

// File: rtl/sram_stream_writer.sv
// rtl/sram_stream_writer.sv - byte stream to SRAM word fill engine (sky130 1RW1R port 0)
//
// Packs a valid/ready byte stream little-endian into DATA_WIDTH-bit words and
// writes them to sequential SRAM addresses with registered one-cycle strobes.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i, base_addr_i    begin a fill at base_addr_i (honored only when idle)
//   in_valid_i, in_ready_o  byte stream handshake
//   in_data_i, in_last_i    byte payload and end-of-fill marker
//   csb0_o, web0_o          SRAM chip select / write enable (active low)
//   wmask0_o, addr0_o       SRAM byte write mask and word address
//   din0_o                  SRAM write data
//   busy_o, done_o          fill in progress / one-cycle end-of-fill pulse
//   full_o                  fill stopped at the last SRAM address (sticky)
//   words_written_o         words written by the current/last fill
module sram_stream_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [7:0]            in_data_i,
    input  logic                  in_last_i,
    output logic                  csb0_o,
    output logic                  web0_o,
    output logic [NUM_WMASKS-1:0] wmask0_o,
    output logic [ADDR_WIDTH-1:0] addr0_o,
    output logic [DATA_WIDTH-1:0] din0_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   words_written_o
);

    localparam int LANE_W = (NUM_WMASKS > 1) ? $clog2(NUM_WMASKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LANE_W-1:0]       lane_q;
    logic [DATA_WIDTH-1:0]   buf_q;
    logic [NUM_WMASKS-1:0]   mask_q;
    logic [ADDR_WIDTH:0]     words_q;
    logic                    full_q;
    logic                    csb0_q;
    logic                    web0_q;
    logic [NUM_WMASKS-1:0]   wmask0_q;
    logic [ADDR_WIDTH-1:0]   addr0_q;
    logic [DATA_WIDTH-1:0]   din0_q;

    logic [DATA_WIDTH-1:0]   buf_d;
    logic [NUM_WMASKS-1:0]   mask_d;
    logic                    hs;
    logic                    word_done;
    logic                    at_top;

    // Ready is a pure state decode so there is no in_valid -> in_ready path.
    assign in_ready_o = (state_q == S_FILL);
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);

    assign hs        = in_valid_i & in_ready_o;
    assign word_done = (lane_q == LANE_W'(NUM_WMASKS - 1)) | in_last_i;
    assign at_top    = &addr_q;

    // Pack buffer with the current byte merged into its lane.
    always_comb begin
        buf_d  = buf_q;
        mask_d = mask_q;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (lane_q == LANE_W'(i)) begin
                buf_d[i*8 +: 8] = in_data_i;
                mask_d[i]       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            lane_q   <= '0;
            buf_q    <= '0;
            mask_q   <= '0;
            words_q  <= '0;
            full_q   <= 1'b0;
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= '0;
            din0_q   <= '0;
        end else begin
            // Strobes last one cycle unless re-armed by another completed word.
            csb0_q <= 1'b1;
            web0_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_FILL;
                        addr_q  <= base_addr_i;
                        lane_q  <= '0;
                        buf_q   <= '0;
                        mask_q  <= '0;
                        words_q <= '0;
                        full_q  <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (hs) begin
                        if (word_done) begin
                            csb0_q   <= 1'b0;
                            web0_q   <= 1'b0;
                            din0_q   <= buf_d;
                            wmask0_q <= mask_d;
                            addr0_q  <= addr_q;
                            buf_q    <= '0;
                            mask_q   <= '0;
                            lane_q   <= '0;
                            addr_q   <= addr_q + 1'b1;
                            words_q  <= words_q + 1'b1;
                            // No wrap: the top address always ends the fill.
                            if (in_last_i || at_top) begin
                                state_q <= S_DONE;
                            end
                            if (at_top) begin
                                full_q <= 1'b1;
                            end
                        end else begin
                            buf_q  <= buf_d;
                            mask_q <= mask_d;
                            lane_q <= lane_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign csb0_o          = csb0_q;
    assign web0_o          = web0_q;
    assign wmask0_o        = wmask0_q;
    assign addr0_o         = addr0_q;
    assign din0_o          = din0_q;
    assign full_o          = full_q;
    assign words_written_o = words_q;

endmodule

// File: tb/tb_sram_stream_writer.sv
// tb/tb_sram_stream_writer.sv - randomized self-checking bench for sram_stream_writer
module tb_sram_stream_writer;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = '0;
    logic          in_last = 1'b0;
    logic          csb0;
    logic          web0;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic          busy;
    logic          done;
    logic          full;
    logic [AW:0]   words_written;

    sram_stream_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .base_addr_i     (base_addr),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_data_i       (in_data),
        .in_last_i       (in_last),
        .csb0_o          (csb0),
        .web0_o          (web0),
        .wmask0_o        (wmask0),
        .addr0_o         (addr0),
        .din0_o          (din0),
        .busy_o          (busy),
        .done_o          (done),
        .full_o          (full),
        .words_written_o (words_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NM-1:0] m;
    } wr_t;

    wr_t        obs_q[$];
    wr_t        exp_q[$];
    logic [7:0] bytes_q[$];
    int         done_cnt = 0;
    int         exp_words;
    int         exp_acc;
    bit         exp_full;

    // Write monitor, sampled 1 time unit after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) check_eq("no_strobe_in_rst", csb0, 1'b1);
            if (!csb0) begin
                check_eq("web_with_csb", web0, 1'b0);
                obs_q.push_back({addr0, din0, wmask0});
            end
            if (done) begin
                done_cnt++;
                check_eq("done_with_strobe", csb0, 1'b0);
                check_eq("ready_low_in_done", in_ready, 1'b0);
            end
        end
    end

    // Reference: chop the accepted byte list into words of NM lanes, stopping
    // at the last byte or after the top address has been written.
    task automatic model(input logic [AW-1:0] base, input bit use_last);
        int            lane = 0;
        logic [AW:0]   a = {1'b0, base};
        logic [DW-1:0] w = '0;
        logic [NM-1:0] m = '0;
        exp_q.delete();
        exp_words = 0;
        exp_full  = 0;
        exp_acc   = 0;
        for (int i = 0; i < bytes_q.size(); i++) begin
            bit lastb;
            w[8*lane +: 8] = bytes_q[i];
            m[lane] = 1'b1;
            lane++;
            exp_acc++;
            lastb = use_last && (i == bytes_q.size() - 1);
            if (lane == NM || lastb) begin
                exp_q.push_back({a[AW-1:0], w, m});
                exp_words++;
                if (a == (1 << AW) - 1) begin
                    exp_full = 1;
                    break;
                end
                if (lastb) break;
                a++;
                lane = 0;
                w = '0;
                m = '0;
            end
        end
    endtask

    task automatic check_reset_vals();
        check_eq("rst_csb0", csb0, 1'b1);
        check_eq("rst_web0", web0, 1'b1);
        check_eq("rst_wmask0", wmask0, '0);
        check_eq("rst_addr0", addr0, '0);
        check_eq("rst_din0", din0, '0);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_full", full, 1'b0);
        check_eq("rst_words", words_written, '0);
    endtask

    task automatic run_fill(input logic [AW-1:0] base, input bit use_last,
                            input int stall_pct, input bit poke);
        int idx = 0;
        int cyc = 0;
        bit hs;
        model(base, use_last);
        @(negedge clk);
        obs_q.delete();
        done_cnt  = 0;
        start     = 1'b1;
        base_addr = base;
        in_valid  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_eq("ready_after_start", in_ready, 1'b1);
        while (busy && cyc < 4000) begin
            if (idx < bytes_q.size() && $urandom_range(99) >= stall_pct) begin
                in_valid = 1'b1;
                in_data  = bytes_q[idx];
                in_last  = use_last && (idx == bytes_q.size() - 1);
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom_range(1));
            end
            start     = poke && ($urandom_range(3) == 0);
            base_addr = AW'($urandom);
            hs = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (hs) idx++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("fill_terminated", cyc < 4000, 1'b1);
        check_eq("bytes_accepted", idx, exp_acc);
        check_eq("num_writes", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                check_eq("wr_addr", obs_q[i].a, exp_q[i].a);
                check_eq("wr_din", obs_q[i].d, exp_q[i].d);
                check_eq("wr_mask", obs_q[i].m, exp_q[i].m);
            end
        end
        check_eq("words_written", words_written, exp_words);
        check_eq("full", full, exp_full);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("idle_after_fill", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Power-on reset.
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        // Asynchronous reset mid-cycle while random traffic is flowing.
        @(negedge clk);
        start = 1'b1;
        base_addr = AW'($urandom);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'b0;
            @(negedge clk);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_vals();
        for (int i = 0; i < 3; i++) begin
            start    = 1'($urandom_range(1));
            in_valid = 1'($urandom_range(1));
            in_data  = 8'($urandom);
            in_last  = 1'($urandom_range(1));
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        rst = 1'b0;

        // Two full words, last on the 8th byte.
        bytes_q.delete();
        for (int i = 0; i < 8; i++) bytes_q.push_back(8'h11 + 8'(i));
        run_fill(8'h10, 1'b1, 0, 1'b0);
        if (obs_q.size() == 2) begin
            check_eq("full_words_w0", obs_q[0], {8'h10, 32'h14131211, 4'hF});
            check_eq("full_words_w1", obs_q[1], {8'h11, 32'h18171615, 4'hF});
        end

        // Partial last word.
        bytes_q.delete();
        for (int i = 0; i < 6; i++) bytes_q.push_back(8'hA0 + 8'(i));
        run_fill(8'h00, 1'b1, 0, 1'b0);
        if (obs_q.size() == 2) begin
            check_eq("partial_w1", obs_q[1], {8'h01, 32'h0000A5A4, 4'h3});
        end

        // End of memory: 12 bytes offered, no last, only 8 accepted.
        bytes_q.delete();
        for (int i = 0; i < 12; i++) bytes_q.push_back(8'($urandom));
        run_fill(8'hFE, 1'b0, 0, 1'b0);
        check_eq("eom_full", full, 1'b1);

        // Stalls with start pokes during the fill.
        bytes_q.delete();
        for (int i = 0; i < 16; i++) bytes_q.push_back(8'($urandom));
        run_fill(8'($urandom_range(0, 8'hF0)), 1'b1, 50, 1'b1);

        // Reset after two accepted bytes discards the partial word.
        @(negedge clk);
        obs_q.delete();
        start = 1'b1;
        base_addr = 8'h20;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hEE;
        @(negedge clk);
        in_data = 8'hDD;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("midfill_rst_no_write", obs_q.size(), 0);
        check_eq("midfill_rst_idle", busy, 1'b0);
        bytes_q.delete();
        for (int i = 0; i < 4; i++) bytes_q.push_back(8'h01 + 8'(i));
        run_fill(8'h40, 1'b1, 0, 1'b0);
        if (obs_q.size() == 1) begin
            check_eq("after_rst_w0", obs_q[0], {8'h40, 32'h04030201, 4'hF});
        end

        // Random fills.
        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(1, 20));
            bytes_q.delete();
            for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
            run_fill(8'($urandom_range(0, 8'hF0)), 1'b1, 40, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
